// File: rtl/seq_mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mult_pkg
//  Purpose  : Shared state encodings and control-word layout for the
//             sequential shift-add multiplier controller.
//  Revision : 1.0  initial release
// ============================================================================
package seq_mult_pkg;

  // Controller state encodings (3-bit, legacy-compatible constants)
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Control-word bit positions
  localparam int CW_LOAD  = 0;
  localparam int CW_ADD   = 1;  // add enable; final add_reg is gated by Q0
  localparam int CW_SHIFT = 2;
  localparam int CW_DEC   = 3;
  localparam int CW_READY = 4;
  localparam int CW_BUSY  = 5;
  localparam int CW_DONE  = 6;
  localparam int CW_W     = 7;

  typedef logic [CW_W-1:0] ctrl_word_t;

  // Moore decode: every control bit is a pure function of the state register
  function automatic ctrl_word_t state_ctrl(input logic [2:0] st);
    ctrl_word_t cw;
    cw = '0;
    case (st)
      S_IDLE:  cw[CW_READY] = 1'b1;
      S_LOAD: begin
        cw[CW_LOAD] = 1'b1;
        cw[CW_BUSY] = 1'b1;
      end
      S_ADD: begin
        cw[CW_ADD]  = 1'b1;
        cw[CW_DEC]  = 1'b1;
        cw[CW_BUSY] = 1'b1;
      end
      S_SHIFT: begin
        cw[CW_SHIFT] = 1'b1;
        cw[CW_BUSY]  = 1'b1;
      end
      S_DONE:  cw[CW_DONE] = 1'b1;
      default: cw = '0;
    endcase
    return cw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mult_controller.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mult_controller
//  Purpose  : Control FSM for the sequential shift-add multiplier. Sequences
//             load/add/shift/decrement strobes for the data path, provides a
//             ready/busy/done handshake and a sticky iteration watchdog flag.
//  Revision : 1.0  initial release
// ============================================================================
module seq_mult_controller
  import seq_mult_pkg::*;
#(
  parameter int BITS = 5   // operand width; also the iteration count
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic Q0,
  input  logic zero,
  output logic load_reg,
  output logic add_reg,
  output logic shift_reg,
  output logic dec_p,
  output logic ready,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int                ITER_W    = $clog2(BITS + 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(BITS - 1);

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [ITER_W-1:0] iter;
  logic              err_q;
  logic              watchdog_trip;
  ctrl_word_t        cw;

  // The last permitted SHIFT has been reached without the data path's P hitting zero
  assign watchdog_trip = (iter == ITER_LAST);

  // Next-state selection; abort overrides every other transition
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_next = S_LOAD;
        S_LOAD:  state_next = S_ADD;
        S_ADD:   state_next = S_SHIFT;
        S_SHIFT: begin
          if (zero)               state_next = S_DONE;
          else if (watchdog_trip) state_next = S_IDLE;
          else                    state_next = S_ADD;
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Iteration counter: cleared on load, counts completed shifts; the watchdog
  // returns to IDLE before it can pass BITS, so it never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter <= '0;
    end else if (!abort) begin
      if (state == S_LOAD)       iter <= '0;
      else if (state == S_SHIFT) iter <= iter + 1'b1;
    end
  end

  // Sticky watchdog error: set on a runaway iteration, cleared by an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (!abort) begin
      if (state == S_IDLE && start)
        err_q <= 1'b0;
      else if (state == S_SHIFT && !zero && watchdog_trip)
        err_q <= 1'b1;
    end
  end

  assign cw = state_ctrl(state);

  // Q0 comes straight from the data path's Q register, so gating the add
  // enable with it stays glitch-free within the cycle
  assign load_reg  = cw[CW_LOAD];
  assign add_reg   = cw[CW_ADD] & Q0;
  assign shift_reg = cw[CW_SHIFT];
  assign dec_p     = cw[CW_DEC];
  assign ready     = cw[CW_READY];
  assign busy      = cw[CW_BUSY];
  assign done      = cw[CW_DONE];
  assign err       = err_q;

endmodule
`default_nettype wire
